// File: rtl/vu_meter_scheduler.sv
// vu_meter_scheduler
// Ballistics controller and L/R channel arbiter for the VU meter path. One
// magnitude/accumulate/ballistics datapath is time-shared between the left
// and right sample strobes. Each channel produces a 7-bit duty word and a
// one-cycle update strobe.
//
// Optional build macro: VU_PEAK_HOLD_EN adds l_peak/r_peak held-peak outputs
// and per-channel hold counters. Without it those ports and registers do not
// exist and all other behaviour is unchanged.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | wait for a pending sample; round-robin grant when both pend
// ACC_L | accumulate |left sample|, bump left count
// ACC_R | accumulate |right sample|, bump right count
// BAL_L | left window complete: attack/release, publish duty + strobe
// BAL_R | right window complete: attack/release, publish duty + strobe

module vu_meter_scheduler #(
  parameter int NUMBER_OF_AVERAGES = 16,
  parameter int RELEASE_SHIFT      = 3,
  parameter int PEAK_HOLD_UPDATES  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       l_data_en,
  input  logic       r_data_en,
  input  logic       audio_enable,
  input  logic [7:0] l_audio_signal,
  input  logic [7:0] r_audio_signal,
  output logic [6:0] l_duty_cycle,
  output logic [6:0] r_duty_cycle,
  output logic       l_duty_stb,
  output logic       r_duty_stb,
`ifdef VU_PEAK_HOLD_EN
  output logic [6:0] l_peak,
  output logic [6:0] r_peak,
`endif
  output logic       overrun
);

  localparam int CW = $clog2(NUMBER_OF_AVERAGES);
  localparam int AW = 7 + CW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC_L = 3'd1,
    S_ACC_R = 3'd2,
    S_BAL_L = 3'd3,
    S_BAL_R = 3'd4
  } state_t;

  state_t state_q, state_d;

  // last_r_q set means the right channel received the most recent grant.
  // Resets to 1 so the left channel wins the first tie.
  logic last_r_q, last_r_d;

  // Per-channel storage, index 0 = left, 1 = right.
  logic [1:0][7:0]    hold_q, hold_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0][AW-1:0] acc_q, acc_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0][6:0]    level_q, level_d;
  logic [1:0]         stb_q, stb_d;
  logic               overrun_q, overrun_d;

  logic [1:0]      data_en;
  logic [1:0][7:0] sample_in;
  logic [1:0]      in_acc;
  logic [1:0]      in_bal;
  logic            sel;

  assign data_en   = {r_data_en, l_data_en};
  assign sample_in = {r_audio_signal, l_audio_signal};
  assign in_acc    = {state_q == S_ACC_R, state_q == S_ACC_L};
  assign in_bal    = {state_q == S_BAL_R, state_q == S_BAL_L};
  assign sel       = (state_q == S_ACC_R) || (state_q == S_BAL_R);

  // Shared datapath operands, steered by the channel the FSM is serving.
  logic [7:0]    sample_sel;
  logic [AW-1:0] acc_sel;
  logic [CW-1:0] cnt_sel;
  logic [6:0]    level_sel;

  assign sample_sel = hold_q[sel];
  assign acc_sel    = acc_q[sel];
  assign cnt_sel    = cnt_q[sel];
  assign level_sel  = level_q[sel];

  logic          cnt_last;
  logic [6:0]    mag;
  logic [AW-1:0] acc_sum;
  logic [6:0]    avg;
  logic [6:0]    diff;
  logic [6:0]    rel_step;
  logic [6:0]    new_level;

  assign cnt_last = (cnt_sel == CW'(NUMBER_OF_AVERAGES - 1));

  // Magnitude of the held sample; -128 has no 7-bit magnitude so it saturates.
  always_comb begin
    mag = sample_sel[6:0];
    if (sample_sel[7]) begin
      if (sample_sel == 8'h80) mag = 7'd127;
      else                     mag = 7'(8'd0 - sample_sel);
    end
  end

  assign acc_sum = acc_sel + {{CW{1'b0}}, mag};
  assign avg     = acc_sel[AW-1:CW];

  // Ballistics: instant attack, proportional release with a minimum step of 1
  // so a small residual still decays to the average.
  always_comb begin
    diff      = level_sel - avg;
    rel_step  = diff >> RELEASE_SHIFT;
    new_level = level_sel;
    if (avg >= level_sel) begin
      new_level = avg;
    end else begin
      if (rel_step == 7'd0) rel_step = 7'd1;
      new_level = level_sel - rel_step;
    end
  end

  // Next-state and grant selection; audio_enable low forces IDLE from any state.
  always_comb begin
    state_d  = state_q;
    last_r_d = last_r_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q[0] && (!pend_q[1] || last_r_q)) begin
          state_d  = S_ACC_L;
          last_r_d = 1'b0;
        end else if (pend_q[1]) begin
          state_d  = S_ACC_R;
          last_r_d = 1'b1;
        end
      end
      S_ACC_L: state_d = cnt_last ? S_BAL_L : S_IDLE;
      S_ACC_R: state_d = cnt_last ? S_BAL_R : S_IDLE;
      S_BAL_L: state_d = S_IDLE;
      S_BAL_R: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!audio_enable) begin
      state_d  = S_IDLE;
      last_r_d = last_r_q;
    end
  end

  // Per-channel capture, accumulate, count and level updates. A strobe that
  // lands in the channel's ACC cycle re-arms pend so the new sample survives.
  always_comb begin
    hold_d  = hold_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    stb_d   = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (in_acc[c]) begin
        pend_d[c] = 1'b0;
        acc_d[c]  = acc_sum;
        cnt_d[c]  = cnt_q[c] + CW'(1);
      end
      if (in_bal[c]) begin
        level_d[c] = new_level;
        acc_d[c]   = '0;
        cnt_d[c]   = '0;
        stb_d[c]   = 1'b1;
      end
      if (data_en[c]) begin
        hold_d[c] = sample_in[c];
        pend_d[c] = 1'b1;
      end
    end
    if (!audio_enable) begin
      hold_d  = '0;
      pend_d  = '0;
      acc_d   = '0;
      cnt_d   = '0;
      level_d = '0;
      stb_d   = '0;
    end
  end

  // Overrun flags a strobe while that channel still has an unserved sample.
  assign overrun_d = audio_enable && ((data_en & pend_q) != 2'b00);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      last_r_q  <= 1'b1;
      hold_q    <= '0;
      pend_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      stb_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_r_q  <= last_r_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      stb_q     <= stb_d;
      overrun_q <= overrun_d;
    end
  end

  assign l_duty_cycle = level_q[0];
  assign r_duty_cycle = level_q[1];
  assign l_duty_stb   = stb_q[0];
  assign r_duty_stb   = stb_q[1];
  assign overrun      = overrun_q;

`ifdef VU_PEAK_HOLD_EN
  localparam int HW = $clog2(PEAK_HOLD_UPDATES + 1);

  logic [1:0][6:0]    peak_q, peak_d;
  logic [1:0][HW-1:0] hcnt_q, hcnt_d;

  // Peak tracks the level published in the same BAL cycle; a lower level
  // only replaces it once the hold counter has run out.
  always_comb begin
    peak_d = peak_q;
    hcnt_d = hcnt_q;
    for (int c = 0; c < 2; c++) begin
      if (in_bal[c]) begin
        if (new_level >= peak_q[c]) begin
          peak_d[c] = new_level;
          hcnt_d[c] = HW'(PEAK_HOLD_UPDATES);
        end else if (hcnt_q[c] == '0) begin
          peak_d[c] = new_level;
        end else begin
          hcnt_d[c] = hcnt_q[c] - HW'(1);
        end
      end
    end
    if (!audio_enable) begin
      peak_d = '0;
      hcnt_d = '0;
    end
  end

  // Peak-hold registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
      hcnt_q <= '0;
    end else begin
      peak_q <= peak_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign l_peak = peak_q[0];
  assign r_peak = peak_q[1];
`endif

endmodule
